// File: rtl/gpmc_sdram_bridge.sv
// gpmc_sdram_bridge: GPMC register port to SDRAM controller bridge with
// write/read FIFOs, prefetch length and auto-incrementing SDRAM pointers.
module gpmc_sdram_bridge #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int SD_ADDR_WIDTH = 25,
    parameter int SD_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int ADDR_STRIDE   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     csn,
    input  logic                     wen,
    input  logic                     oen,
    input  logic [ADDR_WIDTH-1:0]    address,
    input  logic [DATA_WIDTH-1:0]    data_out,
    output logic [DATA_WIDTH-1:0]    data_in,
    output logic [SD_ADDR_WIDTH-1:0] sd_addr,
    output logic                     sd_wr_enable,
    output logic [SD_DATA_WIDTH-1:0] sd_wr_data,
    output logic                     sd_rd_enable,
    input  logic [SD_DATA_WIDTH-1:0] sd_rd_data,
    input  logic                     sd_rd_ready,
    input  logic                     sd_busy,
    input  logic                     sd_ack,
    output logic                     sd_rst
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);
    localparam logic [SD_ADDR_WIDTH-1:0] STEP = SD_ADDR_WIDTH'(ADDR_STRIDE);

    localparam logic [ADDR_WIDTH-1:0] R_DATA = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] R_ALO  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] R_AHI  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] R_CTRL = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] R_LEN  = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;
    state_t state, state_nx;

    logic in_progress;
    logic decode, host_wr, host_rd;
    logic w_data, w_alo, w_ahi, w_ctrl, w_len, r_data;
    logic flush, clr_flags, addr_wr;

    // one decode per chip-select assertion
    assign decode  = !csn && !in_progress && (wen != oen);
    assign host_wr = decode && !wen;
    assign host_rd = decode && !oen;

    assign w_data    = host_wr && (address == R_DATA);
    assign w_alo     = host_wr && (address == R_ALO);
    assign w_ahi     = host_wr && (address == R_AHI);
    assign w_ctrl    = host_wr && (address == R_CTRL);
    assign w_len     = host_wr && (address == R_LEN);
    assign r_data    = host_rd && (address == R_DATA);
    assign flush     = w_ctrl && data_out[0];
    assign clr_flags = w_ctrl && data_out[1];
    assign addr_wr   = w_alo || w_ahi;

    logic [SD_DATA_WIDTH-1:0] wf_mem [FIFO_DEPTH];
    logic [SD_DATA_WIDTH-1:0] rf_mem [FIFO_DEPTH];
    logic [FAW-1:0] wf_wp, wf_rp, rf_wp, rf_rp;
    cnt_t wf_cnt, rf_cnt;
    logic wf_empty, wf_full, rf_empty, rf_full;
    logic wf_push, wf_pop, rf_push, rf_pop;

    assign wf_empty = (wf_cnt == '0);
    assign wf_full  = (wf_cnt == DEPTH_C);
    assign rf_empty = (rf_cnt == '0);
    assign rf_full  = (rf_cnt == DEPTH_C);

    logic [SD_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [31:0] wp_ext, rp_ext;
    logic [15:0] len;
    logic wr_ovf, rd_unf;
    logic req_addr_dirty, req_len_dirty, req_flushed;
    logic issue_wr, issue_rd, issue, wr_done, rd_done, rd_fill;
    logic discard;

    assign wp_ext  = 32'(wr_ptr);
    assign rp_ext  = 32'(rd_ptr);
    assign issue   = issue_wr || issue_rd;
    // a flush orphans the in-flight request: its pop/decrement/data are dropped
    assign discard = req_flushed || flush;
    assign wf_push = w_data && !wf_full;
    assign wf_pop  = wr_done && !discard;
    assign rf_push = rd_fill && !discard;
    assign rf_pop  = r_data && !rf_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        sd_wr_enable = 1'b0;
        sd_rd_enable = 1'b0;
        issue_wr     = 1'b0;
        issue_rd     = 1'b0;
        wr_done      = 1'b0;
        rd_done      = 1'b0;
        rd_fill      = 1'b0;
        if (sd_rst) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!sd_busy && !flush) begin
                        if (!wf_empty) begin
                            issue_wr = 1'b1;
                            state_nx = WR;
                        end else if (len != '0 && rf_cnt < DEPTH_C) begin
                            issue_rd = 1'b1;
                            state_nx = RD;
                        end
                    end
                end
                WR: begin
                    sd_wr_enable = 1'b1;
                    if (sd_ack) begin
                        wr_done  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                RD: begin
                    sd_rd_enable = 1'b1;
                    if (sd_ack) begin
                        rd_done  = 1'b1;
                        state_nx = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sd_rd_ready) begin
                        rd_fill  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wf_push) wf_mem[wf_wp] <= data_out[SD_DATA_WIDTH-1:0];
        if (rf_push) rf_mem[rf_wp] <= sd_rd_data;
    end

    logic [DATA_WIDTH-1:0] rd_val;
    logic [15:0] status;
    logic [8:0] rc9;
    logic [7:0] rc_sat;
    logic busy;

    assign rc9    = 9'(rf_cnt);
    assign rc_sat = rc9[8] ? 8'hFF : rc9[7:0];
    assign busy   = (state != IDLE) || sd_busy || !wf_empty || (len != '0);
    assign status = {rc_sat, sd_rst, rd_unf, wr_ovf, busy,
                     rf_full, rf_empty, wf_full, wf_empty};

    always_comb begin
        rd_val = '0;
        case (address)
            R_DATA:  rd_val = rf_empty ? '0 : DATA_WIDTH'(rf_mem[rf_rp]);
            R_ALO:   rd_val = DATA_WIDTH'(wp_ext[15:0]);
            R_AHI:   rd_val = DATA_WIDTH'(wp_ext[31:16]);
            R_CTRL:  rd_val = DATA_WIDTH'(status);
            R_LEN:   rd_val = DATA_WIDTH'(len);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_progress    <= 1'b0;
            data_in        <= '0;
            sd_addr        <= '0;
            sd_wr_data     <= '0;
            sd_rst         <= 1'b0;
            wf_wp          <= '0;
            wf_rp          <= '0;
            wf_cnt         <= '0;
            rf_wp          <= '0;
            rf_rp          <= '0;
            rf_cnt         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            len            <= '0;
            wr_ovf         <= 1'b0;
            rd_unf         <= 1'b0;
            req_addr_dirty <= 1'b0;
            req_len_dirty  <= 1'b0;
            req_flushed    <= 1'b0;
        end else begin
            if (csn)         in_progress <= 1'b0;
            else if (decode) in_progress <= 1'b1;
            if (host_rd) data_in <= rd_val;
            if (w_ctrl)  sd_rst  <= data_out[3];

            if (flush) begin
                wf_wp  <= wf_rp;
                wf_cnt <= '0;
                rf_wp  <= rf_rp;
                rf_cnt <= '0;
            end else begin
                if (wf_push) wf_wp <= wf_wp + FAW'(1);
                if (wf_pop)  wf_rp <= wf_rp + FAW'(1);
                if (rf_push) rf_wp <= rf_wp + FAW'(1);
                if (rf_pop)  rf_rp <= rf_rp + FAW'(1);
                wf_cnt <= wf_cnt + cnt_t'(wf_push) - cnt_t'(wf_pop);
                rf_cnt <= rf_cnt + cnt_t'(rf_push) - cnt_t'(rf_pop);
            end

            if (clr_flags)              wr_ovf <= 1'b0;
            else if (w_data && wf_full) wr_ovf <= 1'b1;
            if (clr_flags)              rd_unf <= 1'b0;
            else if (r_data && rf_empty) rd_unf <= 1'b1;

            // host writes during a request only steer the next one
            if (issue) begin
                req_addr_dirty <= addr_wr;
                req_len_dirty  <= w_len;
                req_flushed    <= 1'b0;
            end else if (state == IDLE) begin
                req_addr_dirty <= 1'b0;
                req_len_dirty  <= 1'b0;
                req_flushed    <= 1'b0;
            end else begin
                if (addr_wr)         req_addr_dirty <= 1'b1;
                if (w_len || flush)  req_len_dirty  <= 1'b1;
                if (flush)           req_flushed    <= 1'b1;
            end

            if (issue_wr) begin
                sd_addr    <= wr_ptr;
                sd_wr_data <= wf_mem[wf_rp];
            end
            if (issue_rd) sd_addr <= rd_ptr;

            if (wr_done && !req_addr_dirty) wr_ptr <= wr_ptr + STEP;
            if (rd_done && !req_addr_dirty) rd_ptr <= rd_ptr + STEP;
            if (w_alo) begin
                wr_ptr <= SD_ADDR_WIDTH'({wp_ext[31:16], data_out[15:0]});
                rd_ptr <= SD_ADDR_WIDTH'({rp_ext[31:16], data_out[15:0]});
            end
            if (w_ahi) begin
                wr_ptr <= SD_ADDR_WIDTH'({data_out[15:0], wp_ext[15:0]});
                rd_ptr <= SD_ADDR_WIDTH'({data_out[15:0], rp_ext[15:0]});
            end

            if (flush)
                len <= '0;
            else if (w_len)
                len <= data_out[15:0];
            else if (rd_done && !req_len_dirty && len != '0)
                len <= len - 16'd1;
        end
    end
endmodule

// File: tb/tb_gpmc_sdram_bridge.sv
// Self-checking bench for gpmc_sdram_bridge with an SDRAM controller stub
// that returns addr[7:0] as read data.
module tb_gpmc_sdram_bridge;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csn = 1'b1, wen = 1'b1, oen = 1'b1;
    logic [3:0]  address = '0;
    logic [15:0] data_out = '0;
    logic [15:0] data_in;
    logic [24:0] sd_addr;
    logic        sd_wr_enable, sd_rd_enable, sd_rst;
    logic [7:0]  sd_wr_data;
    logic [7:0]  sd_rd_data = '0;
    logic        sd_rd_ready = 1'b0, sd_busy = 1'b0, sd_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    gpmc_sdram_bridge dut (
        .clk(clk), .rst(rst), .csn(csn), .wen(wen), .oen(oen),
        .address(address), .data_out(data_out), .data_in(data_in),
        .sd_addr(sd_addr), .sd_wr_enable(sd_wr_enable),
        .sd_wr_data(sd_wr_data), .sd_rd_enable(sd_rd_enable),
        .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready),
        .sd_busy(sd_busy), .sd_ack(sd_ack), .sd_rst(sd_rst)
    );

    always #5 clk = ~clk;

    // controller stub state and logs
    bit ack_en = 1'b1, rdy_en = 1'b1, rand_busy = 1'b0;
    bit rd_pend = 1'b0;
    int ack_dly = 0, rdy_dly = 0;
    logic [24:0] rd_pend_a = '0;
    logic [24:0] wr_log_a[$];
    logic [7:0]  wr_log_d[$];
    logic [24:0] rd_log_a[$];
    logic [7:0]  exp_wd[$];

    always @(negedge clk) begin
        sd_ack      = 1'b0;
        sd_rd_ready = 1'b0;
        sd_busy     = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (rd_pend) begin
            if (rdy_en) begin
                if (rdy_dly == 0) begin
                    sd_rd_ready = 1'b1;
                    sd_rd_data  = rd_pend_a[7:0];
                    rd_pend     = 1'b0;
                end else rdy_dly--;
            end
        end else if ((sd_wr_enable || sd_rd_enable) && ack_en) begin
            if (ack_dly == 0) begin
                sd_ack  = 1'b1;
                ack_dly = $urandom_range(0, 2);
                if (sd_wr_enable) begin
                    wr_log_a.push_back(sd_addr);
                    wr_log_d.push_back(sd_wr_data);
                end else begin
                    rd_log_a.push_back(sd_addr);
                    rd_pend   = 1'b1;
                    rd_pend_a = sd_addr;
                    rdy_dly   = $urandom_range(0, 3);
                end
            end else ack_dly--;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic host_acc(input bit w, input logic [3:0] a,
                            input logic [15:0] d, input int hold,
                            output logic [15:0] q);
        @(negedge clk);
        csn = 1'b0; wen = !w; oen = w; address = a; data_out = d;
        repeat (hold) @(negedge clk);
        q = data_in;
        csn = 1'b1; wen = 1'b1; oen = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        logic [15:0] q;
        host_acc(1'b1, a, d, 1, q);
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] q);
        host_acc(1'b0, a, 16'h0, 1, q);
    endtask

    task automatic set_addr(input logic [24:0] a);
        wr(4'd1, a[15:0]);
        wr(4'd2, {7'd0, a[24:16]});
    endtask

    task automatic wait_idle(input string tag);
        logic [15:0] s;
        int n;
        n = 0;
        do begin
            rd(4'd3, s);
            n++;
        end while (s[4] && n < 400);
        check({tag, "_idle"}, s[4], 0);
    endtask

    task automatic check_wr_log(input string tag, input logic [24:0] base);
        logic [24:0] ea;
        check({tag, "_wcnt"}, wr_log_a.size(), exp_wd.size());
        for (int i = 0; i < exp_wd.size() && i < wr_log_a.size(); i++) begin
            ea = base + 25'(i);
            check($sformatf("%s_wa%0d", tag, i), wr_log_a[i], ea);
            check($sformatf("%s_wd%0d", tag, i), wr_log_d[i], exp_wd[i]);
        end
    endtask

    task automatic clear_logs();
        wr_log_a.delete();
        wr_log_d.delete();
        rd_log_a.delete();
        exp_wd.delete();
    endtask

    typedef struct packed {
        bit          w;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] q;
        int n, sz0;

        tbl[0]  = '{1'b0, 4'd3, 16'h0000, 16'h0005};
        tbl[1]  = '{1'b1, 4'd1, 16'h1234, 16'h0000};
        tbl[2]  = '{1'b0, 4'd1, 16'h0000, 16'h1234};
        tbl[3]  = '{1'b1, 4'd2, 16'hFFFF, 16'h0000};
        tbl[4]  = '{1'b0, 4'd2, 16'h0000, 16'h01FF};
        tbl[5]  = '{1'b0, 4'd1, 16'h0000, 16'h1234};
        tbl[6]  = '{1'b1, 4'd3, 16'h0008, 16'h0000};
        tbl[7]  = '{1'b0, 4'd3, 16'h0000, 16'h0085};
        tbl[8]  = '{1'b1, 4'd4, 16'h0007, 16'h0000};
        tbl[9]  = '{1'b0, 4'd4, 16'h0000, 16'h0007};
        tbl[10] = '{1'b0, 4'd3, 16'h0000, 16'h0095};
        tbl[11] = '{1'b0, 4'd5, 16'h0000, 16'h0000};
        tbl[12] = '{1'b1, 4'd6, 16'hFFFF, 16'h0000};
        tbl[13] = '{1'b1, 4'd3, 16'h0001, 16'h0000};
        tbl[14] = '{1'b0, 4'd4, 16'h0000, 16'h0000};
        tbl[15] = '{1'b0, 4'd3, 16'h0000, 16'h0005};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {data_in, sd_addr, sd_wr_enable, sd_wr_data, sd_rd_enable, sd_rst},
              64'h0);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            else begin
                rd(tbl[i].a, q);
                check($sformatf("vec%0d", i), q, tbl[i].exp);
            end
        end

        // sd_rst aborts a pending write, FIFO contents survive
        clear_logs();
        set_addr(25'h77);
        ack_en = 1'b0;
        wr(4'd0, 16'h0033);
        repeat (2) @(negedge clk);
        check("sdrst_wr_en", sd_wr_enable, 1);
        check("sdrst_addr", sd_addr, 25'h77);
        wr(4'd3, 16'h0008);
        check("sdrst_wr_off", sd_wr_enable, 0);
        check("sdrst_out", sd_rst, 1);
        rd(4'd3, q);
        check("sdrst_status", q, 16'h0094);
        wr(4'd3, 16'h0000);
        ack_en = 1'b1;
        wait_idle("sdrst");
        exp_wd.push_back(8'h33);
        check_wr_log("sdrst", 25'h77);

        // pointer wrap, with a long chip-select on the second write
        clear_logs();
        set_addr(25'h1FFFFFF);
        wr(4'd0, 16'h00A5);
        host_acc(1'b1, 4'd0, 16'h005A, 3, q);
        exp_wd.push_back(8'hA5);
        exp_wd.push_back(8'h5A);
        wait_idle("wrap");
        check_wr_log("wrap", 25'h1FFFFFF);
        rd(4'd1, q);
        check("wrap_ptr_lo", q, 16'h0001);
        rd(4'd2, q);
        check("wrap_ptr_hi", q, 16'h0000);

        // prefetch of four words, then underflow
        clear_logs();
        set_addr(25'h100);
        wr(4'd4, 16'd4);
        wait_idle("pref");
        check("pref_rcnt", rd_log_a.size(), 4);
        for (int i = 0; i < 4 && i < rd_log_a.size(); i++)
            check($sformatf("pref_ra%0d", i), rd_log_a[i], 25'h100 + 25'(i));
        host_acc(1'b0, 4'd0, 16'h0, 3, q);
        check("pref_d0", q, 16'h0000);
        for (int i = 1; i < 4; i++) begin
            rd(4'd0, q);
            check($sformatf("pref_d%0d", i), q, 16'(i));
        end
        rd(4'd4, q);
        check("pref_len", q, 16'h0000);
        rd(4'd0, q);
        check("unf_data", q, 16'h0000);
        rd(4'd3, q);
        check("unf_status", q, 16'h0045);
        wr(4'd3, 16'h0002);
        rd(4'd3, q);
        check("unf_clear", q, 16'h0005);

        // write FIFO overflow with acks held off
        clear_logs();
        set_addr(25'h40);
        ack_en = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(4'd0, 16'(8'h10 + i));
            if (i < DEPTH) exp_wd.push_back(8'(8'h10 + i));
        end
        rd(4'd3, q);
        check("ovf_status", q, 16'h0036);
        wr(4'd3, 16'h0002);
        rd(4'd3, q);
        check("ovf_clear", q, 16'h0016);
        ack_en = 1'b1;
        wait_idle("ovf");
        check_wr_log("ovf", 25'h40);

        // long prefetch stalls at a full read FIFO; flush in RD_WAIT
        clear_logs();
        set_addr(25'h2F0);
        wr(4'd4, 16'd100);
        n = 0;
        do begin
            rd(4'd3, q);
            n++;
        end while (q[15:8] != 8'd16 && n < 300);
        check("len100_fill", q[15:8], 16);
        repeat (10) @(negedge clk);
        rd(4'd3, q);
        check("len100_status", q, 16'h1019);
        rd(4'd4, q);
        check("len100_len", q, 16'd84);
        rdy_en = 1'b0;
        sz0 = rd_log_a.size();
        rd(4'd0, q);
        check("len100_pop", q, 16'h00F0);
        n = 0;
        while (rd_log_a.size() == sz0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("flush_req_seen", rd_log_a.size(), sz0 + 1);
        wr(4'd3, 16'h0001);
        rdy_en = 1'b1;
        repeat (10) @(negedge clk);
        rd(4'd3, q);
        check("flush_status", q, 16'h0005);
        rd(4'd4, q);
        check("flush_len", q, 16'h0000);
        rd(4'd0, q);
        check("flush_dropped", q, 16'h0000);
        wr(4'd3, 16'h0002);

        // randomized bursts against address arithmetic
        rand_busy = 1'b1;
        for (int it = 0; it < 6; it++) begin
            logic [24:0] a;
            logic [7:0]  b;
            int nw, nr;
            a  = 25'($urandom);
            nw = $urandom_range(1, DEPTH);
            nr = $urandom_range(1, DEPTH);
            set_addr(a);
            clear_logs();
            for (int i = 0; i < nw; i++) begin
                b = 8'($urandom);
                exp_wd.push_back(b);
                wr(4'd0, {8'd0, b});
            end
            wr(4'd4, 16'(nr));
            wait_idle($sformatf("rnd%0d", it));
            check_wr_log($sformatf("rnd%0d", it), a);
            for (int i = 0; i < nr; i++) begin
                b = 8'(a + 25'(i));
                rd(4'd0, q);
                check($sformatf("rnd%0d_rd%0d", it, i), q, {8'd0, b});
            end
            rd(4'd3, q);
            check($sformatf("rnd%0d_status", it), q & 16'hFFEF, 16'h0005);
        end
        rand_busy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
